dmux_8_way: RTL and testbench

//   1-to-8 demultiplexer with registered outputs. Routes input word `in` to

---
 rtl/dmux_8_way_if.sv | 26 ++
 rtl/dmux_8_way.sv | 34 +++
 tb/tb_dmux_8_way.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmux_8_way_if.sv
// Bundle of the demultiplexer data input, destination select and the
// eight routed outputs. The master drives in/sel, the slave drives a..h.
interface dmux_8_way_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in;
    logic [2:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] h;

    modport master (
        output in, sel,
        input  a, b, c, d, e, f, g, h
    );

    modport slave (
        input  in, sel,
        output a, b, c, d, e, f, g, h
    );
endinterface

// File: rtl/dmux_8_way.sv
// Registered 1-to-8 demultiplexer: each rising edge loads `in` into the output
// picked by `sel` and clears the other seven, so at most one output is live.
module dmux_8_way #(
    parameter int WIDTH = 1
) (
    input logic         clk,
    input logic         rst_n,
    dmux_8_way_if.slave bus
);
    logic [WIDTH-1:0] out_q [8];

    // Every output reloads each cycle, so the previous target drops to zero
    // on the same edge the new one loads; an unknown sel propagates as X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                out_q[i] <= (bus.sel == 3'(i)) ? bus.in : '0;
            end
        end
    end

    assign bus.a = out_q[0];
    assign bus.b = out_q[1];
    assign bus.c = out_q[2];
    assign bus.d = out_q[3];
    assign bus.e = out_q[4];
    assign bus.f = out_q[5];
    assign bus.g = out_q[6];
    assign bus.h = out_q[7];
endmodule

// File: tb/tb_dmux_8_way.sv
// Directed and random checks of dmux_8_way at WIDTH=8 and WIDTH=1 against an
// array model: after each edge the selected slot holds `in`, all others zero.
module tb_dmux_8_way;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dmux_8_way_if #(.WIDTH(8)) bus_w ();
    dmux_8_way_if #(.WIDTH(1)) bus_n ();

    dmux_8_way #(.WIDTH(8)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    dmux_8_way #(.WIDTH(1)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    logic [7:0] obs_w [8];
    logic       obs_n [8];
    logic [7:0] exp_w [8];
    logic       exp_n [8];
    int         vectors     = 0;
    int         miscompares = 0;

    assign obs_w[0] = bus_w.a;
    assign obs_w[1] = bus_w.b;
    assign obs_w[2] = bus_w.c;
    assign obs_w[3] = bus_w.d;
    assign obs_w[4] = bus_w.e;
    assign obs_w[5] = bus_w.f;
    assign obs_w[6] = bus_w.g;
    assign obs_w[7] = bus_w.h;
    assign obs_n[0] = bus_n.a;
    assign obs_n[1] = bus_n.b;
    assign obs_n[2] = bus_n.c;
    assign obs_n[3] = bus_n.d;
    assign obs_n[4] = bus_n.e;
    assign obs_n[5] = bus_n.f;
    assign obs_n[6] = bus_n.g;
    assign obs_n[7] = bus_n.h;

    task automatic checkOutput(input string tag);
        int live;
        live = 0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            assert (obs_w[i] === exp_w[i]) else begin
                miscompares++;
                $error("[TB] FAIL %s wide out%0d: observed %h expected %h",
                       tag, i, obs_w[i], exp_w[i]);
            end
            vectors++;
            assert (obs_n[i] === exp_n[i]) else begin
                miscompares++;
                $error("[TB] FAIL %s narrow out%0d: observed %b expected %b",
                       tag, i, obs_n[i], exp_n[i]);
            end
            if (obs_w[i] !== 8'h00) live++;
        end
        vectors++;
        assert (live <= 1) else begin
            miscompares++;
            $error("[TB] FAIL %s onehot: observed %0d live outputs expected at most 1",
                   tag, live);
        end
    endtask

    // Drive between edges, confirm nothing moves before the edge, then
    // advance the model one edge and compare.
    task automatic applyStimulus(input logic r, input logic [7:0] din,
                                 input logic [2:0] s, input string tag);
        @(negedge clk);
        rst_n     = r;
        bus_w.in  = din;
        bus_w.sel = s;
        bus_n.in  = din[0];
        bus_n.sel = s;
        #2;
        checkOutput({tag, "/hold"});
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_w[i] = 8'h00;
            exp_n[i] = 1'b0;
        end
        if (r) begin
            exp_w[s] = din;
            exp_n[s] = din[0];
        end
        checkOutput(tag);
    endtask

    initial begin
        logic [7:0] rin;
        logic [2:0] rsel;
        logic       rrst;

        rst_n     = 1'b0;
        bus_w.in  = 8'h01;
        bus_w.sel = 3'd3;
        bus_n.in  = 1'b1;
        bus_n.sel = 3'd3;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_w[i] = 8'h00;
            exp_n[i] = 1'b0;
        end
        checkOutput("reset0");

        applyStimulus(1'b0, 8'h01, 3'd3, "reset1");
        applyStimulus(1'b0, 8'h01, 3'd3, "reset2");

        for (int s = 0; s < 8; s++) applyStimulus(1'b1, 8'h00, 3'(s), "sweep_zero");
        for (int s = 0; s < 8; s++) applyStimulus(1'b1, 8'h01, 3'(s), "walk_one");

        applyStimulus(1'b1, 8'h01, 3'd7, "midrst_h");
        applyStimulus(1'b0, 8'h01, 3'd7, "midrst_clr");
        applyStimulus(1'b1, 8'h01, 3'd2, "midrst_c");

        applyStimulus(1'b1, 8'hA5, 3'd4, "wide_a5");
        applyStimulus(1'b1, 8'h00, 3'd4, "wide_00");
        applyStimulus(1'b1, 8'hFF, 3'd0, "wide_ff_a");
        applyStimulus(1'b1, 8'h80, 3'd7, "wide_80_h");

        for (int n = 0; n < 60; n++) begin
            rin  = 8'($urandom);
            rsel = 3'($urandom_range(0, 7));
            rrst = ($urandom_range(0, 9) != 0);
            applyStimulus(rrst, rin, rsel, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
